ifetch_responder: RTL and testbench

Instruction-fetch responder that serves the core's fetch-address/instruction interface from the memory side. Accepts word-aligned fetch requests over a valid/ready handshake, reads a local instruction RAM through a fixed-latency pipeline, and returns responses in order through a response FIFO that absorbs core-side stalls. A load port preloads or patches program contents. Used when the core moves from a combinational instruction memory to a pipelined or stallable fetch.

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifetch_rsp_fifo.sv | 60 ++++++
 rtl/ifetch_responder.sv | 169 ++++++++++++++++
 tb/tb_ifetch_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants and response record for the instruction-fetch responder
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam int          LATENCY_MIN = 1;
  localparam int          LATENCY_MAX = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/ifetch_rsp_fifo.sv
// rtl/ifetch_rsp_fifo.sv - synchronous FIFO of fetch response records
module ifetch_rsp_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output logic empty,
  output rsp_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rsp_t          slots [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - pipelined, stallable instruction-fetch responder over a local RAM
// Define IFETCH_MISALIGN_TRAP_EN to turn misaligned fetches into NOP responses with err set.
module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [31:0]                    req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [31:0]                    rsp_instr_o,
  output logic [31:0]                    rsp_addr_o,
  output logic                           rsp_err_o,
  input  logic                           load_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                    load_data_i,
  output logic                           busy_o
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int CAP = LATENCY + 1;
  localparam int CW  = $clog2(CAP + 1);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("ifetch_responder: LATENCY out of range");
  end

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rd_word;
  logic [CW-1:0] cnt;
  logic [AW-1:0] req_idx;
  logic          req_oor;
  logic          req_err;
  logic          req_fire;
  logic          rsp_fire;

  logic          s0_valid;
  logic [31:0]   s0_addr;
  logic          s0_err;
  rsp_t          s0_rec;

  logic          pipe_valid;
  rsp_t          pipe_rec;

  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  rsp_t          fifo_head;
  logic          out_valid;
  rsp_t          out_rec;

  assign req_idx = req_addr_i[AW+1:2];
  assign req_oor = |req_addr_i[31:AW+2];

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign req_err = req_oor | (req_addr_i[1:0] != 2'b00);
`else
  assign req_err = req_oor;
`endif

  // Admission depends only on the registered credit count, so the FIFO can never overflow.
  assign req_ready_o = (cnt < CW'(CAP));
  assign req_fire    = req_valid_i & req_ready_o;
  assign busy_o      = (cnt != '0);

  // Reads sample the array before this cycle's load write lands (read-before-write).
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem[load_addr_i] <= load_data_i;
    end
    if (req_fire && !req_err) begin
      rd_word <= mem[req_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
    end else begin
      s0_valid <= req_fire;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_fire) begin
      s0_addr <= req_addr_i;
      s0_err  <= req_err;
    end
  end

  always_comb begin
    s0_rec       = '0;
    s0_rec.instr = s0_err ? NOP_INSTR : rd_word;
    s0_rec.addr  = s0_addr;
    s0_rec.err   = s0_err;
  end

  if (LATENCY == 1) begin : g_no_delay
    assign pipe_valid = s0_valid;
    assign pipe_rec   = s0_rec;
  end else begin : g_delay
    logic [LATENCY-2:0] dly_valid;
    rsp_t               dly_rec [LATENCY-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        dly_valid <= '0;
      end else begin
        dly_valid[0] <= s0_valid;
        for (int i = 1; i < LATENCY - 1; i++) begin
          dly_valid[i] <= dly_valid[i-1];
        end
      end
    end

    always_ff @(posedge clk_i) begin
      dly_rec[0] <= s0_rec;
      for (int i = 1; i < LATENCY - 1; i++) begin
        dly_rec[i] <= dly_rec[i-1];
      end
    end

    assign pipe_valid = dly_valid[LATENCY-2];
    assign pipe_rec   = dly_rec[LATENCY-2];
  end

  // An empty FIFO is bypassed so the pipeline output is visible in its arrival cycle;
  // it is only buffered when it cannot leave immediately.
  assign out_valid = ~fifo_empty | pipe_valid;
  assign out_rec   = fifo_empty ? pipe_rec : fifo_head;
  assign rsp_fire  = out_valid & rsp_ready_i;
  assign fifo_push = pipe_valid & ~(fifo_empty & rsp_ready_i);
  assign fifo_pop  = ~fifo_empty & rsp_ready_i;

  ifetch_rsp_fifo #(
    .DEPTH(CAP)
  ) u_rsp_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (fifo_push),
    .push_data(pipe_rec),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign rsp_valid_o = out_valid;
  assign rsp_instr_o = out_valid ? out_rec.instr : 32'h0;
  assign rsp_addr_o  = out_valid ? out_rec.addr  : 32'h0;
  assign rsp_err_o   = out_valid & out_rec.err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else begin
      case ({req_fire, rsp_fire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// tb/tb_ifetch_responder.sv - scoreboard bench for ifetch_responder
module tb_ifetch_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_instr_o;
  logic [31:0] rsp_addr_o;
  logic        rsp_err_o;
  logic        load_we_i;
  logic [7:0]  load_addr_i;
  logic [31:0] load_data_i;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  ifetch_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_instr_o(rsp_instr_o),
    .rsp_addr_o (rsp_addr_o),
    .rsp_err_o  (rsp_err_o),
    .load_we_i  (load_we_i),
    .load_addr_i(load_addr_i),
    .load_data_i(load_data_i),
    .busy_o     (busy_o)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q [$];
  int          acc_q [$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] prog [6];
  int          errs = 0;
  int          checks = 0;
  int          cyc_n = 0;
  int          n_acc = 0;
  int          n_rsp = 0;
  bit          lat_on = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_rsp;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a[31:2] >= 30'(DEPTH));
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) e.err = 1'b1;
`endif
    e.instr = e.err ? 32'h00000013 : mem_m[a[9:2]];
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc_n++;
  endtask

  // One clock: drive inputs, score the transfers that the coming edge will perform, advance.
  task automatic cyc(input logic rv, input logic [31:0] a, input logic ry,
                     input logic we, input logic [7:0] la, input logic [31:0] ld);
    exp_t e;
    int   t;
    if (prev_stall) begin
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_data", {rsp_instr_o, rsp_addr_o}, prev_rsp);
    end
    req_valid_i = rv;
    req_addr_i  = a;
    rsp_ready_i = ry;
    load_we_i   = we;
    load_addr_i = la;
    load_data_i = ld;
    if (rsp_valid_o && ry) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        chk("rsp_instr", rsp_instr_o, e.instr);
        chk("rsp_addr", rsp_addr_o, e.addr);
        chk("rsp_err", rsp_err_o, e.err);
        if (lat_on) chk("latency", cyc_n - t, LAT);
      end
      n_rsp++;
    end
    if (rv && req_ready_o) begin
      exp_q.push_back(model(a));
      acc_q.push_back(cyc_n);
      n_acc++;
    end
    if (we) mem_m[la] = ld;
    prev_stall = rsp_valid_o && !ry;
    prev_rsp   = {rsp_instr_o, rsp_addr_o};
    step();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
      guard++;
    end
    chk("drain_done", exp_q.size(), 0);
    chk("idle_busy", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int r0;
    prog[0] = 32'h00500093;
    prog[1] = 32'h00a00113;
    prog[2] = 32'h002081b3;
    prog[3] = 32'h00000013;
    prog[4] = 32'h00c00213;
    prog[5] = 32'h12345678;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0;
    load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    step();
    step();
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_instr", rsp_instr_o, 0);
    chk("rst_rsp_addr", rsp_addr_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1, 1'b1, 8'(i), prog[i]);

    // Back-to-back with the core always ready.
    lat_on = 1;
    n0 = n_acc;
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b1, 1'b0, 8'h0, 32'h0);
    chk("b2b_accepted", n_acc - n0, 4);
    drain();
    lat_on = 0;

    // Core stalled: only CAP requests get in.
    n0 = n_acc;
    r0 = n_rsp;
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0, 8'h0, 32'h0);
    chk("stall_accepted", n_acc - n0, 3);
    chk("stall_ready", req_ready_o, 0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    chk("ready_back", req_ready_o, 1);
    drain();
    chk("stall_rsp_count", n_rsp - r0, 3);

    // Out-of-range and misaligned fetches.
    lat_on = 1;
    cyc(1'b1, 32'h00000400, 1'b1, 1'b0, 8'h0, 32'h0);
    cyc(1'b1, 32'h00000006, 1'b1, 1'b0, 8'h0, 32'h0);
    cyc(1'b1, 32'hfffffffc, 1'b1, 1'b0, 8'h0, 32'h0);
    cyc(1'b1, 32'h000003fc, 1'b1, 1'b0, 8'h0, 32'h0);
    drain();

    // Same-cycle write and read of word 5, then a read of the new value.
    cyc(1'b1, 32'h00000014, 1'b1, 1'b1, 8'd5, 32'hdeadbeef);
    cyc(1'b1, 32'h00000014, 1'b1, 1'b0, 8'h0, 32'h0);
    drain();
    lat_on = 0;

    // Reset with two requests in flight.
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 8'h0, 32'h0);
    chk("pre_rst_busy", busy_o, 1);
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
    exp_q.delete();
    acc_q.delete();
    prev_stall = 0;
    chk("midrst_ready", req_ready_o, 1);
    chk("midrst_busy", busy_o, 0);
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_rsp", rsp_valid_o, 0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0);
    end

    // Random valid/ready mix over the loaded words.
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 1)), 32'($urandom_range(0, 5) * 4),
          1'($urandom_range(0, 1)), 1'b0, 8'h0, 32'h0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
